// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared definitions for the seven-segment display blocks:
//               segment-pattern constants {a,b,c,d,e,f,g} (a = MSB), the
//               scan-decoder state enum and the segment vector type.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    typedef logic [6:0] seg_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    localparam seg_t c_SEG_0 = 7'b1111110;
    localparam seg_t c_SEG_1 = 7'b0110000;
    localparam seg_t c_SEG_2 = 7'b1101101;
    localparam seg_t c_SEG_3 = 7'b1111001;
    localparam seg_t c_SEG_4 = 7'b0110011;
    localparam seg_t c_SEG_5 = 7'b1011011;
    localparam seg_t c_SEG_6 = 7'b1011111;
    localparam seg_t c_SEG_7 = 7'b1110000;
    localparam seg_t c_SEG_8 = 7'b1111111;
    localparam seg_t c_SEG_9 = 7'b1111011;
    localparam seg_t c_SEG_A = 7'b1110111;
    localparam seg_t c_SEG_B = 7'b0011111;
    localparam seg_t c_SEG_C = 7'b1001110;
    localparam seg_t c_SEG_D = 7'b0111101;
    localparam seg_t c_SEG_E = 7'b1001111;
    localparam seg_t c_SEG_F = 7'b1000111;

endpackage
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pattern_decode
// Description : Combinational map from a 7-segment pattern to its hex value.
//               Unknown patterns (blank included) give value 0 with o_ok = 0.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  seg_t       i_pattern,
    output logic [3:0] o_value,
    output logic       o_ok
);

    // Table lookup of the sixteen hex glyphs
    always_comb begin
        o_value = 4'h0;
        o_ok    = 1'b1;
        case (i_pattern)
            c_SEG_0: o_value = 4'h0;
            c_SEG_1: o_value = 4'h1;
            c_SEG_2: o_value = 4'h2;
            c_SEG_3: o_value = 4'h3;
            c_SEG_4: o_value = 4'h4;
            c_SEG_5: o_value = 4'h5;
            c_SEG_6: o_value = 4'h6;
            c_SEG_7: o_value = 4'h7;
            c_SEG_8: o_value = 4'h8;
            c_SEG_9: o_value = 4'h9;
            c_SEG_A: o_value = 4'hA;
            c_SEG_B: o_value = 4'hB;
            c_SEG_C: o_value = 4'hC;
            c_SEG_D: o_value = 4'hD;
            c_SEG_E: o_value = 4'hE;
            c_SEG_F: o_value = 4'hF;
            default: begin
                o_value = 4'h0;
                o_ok    = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_decoder
// Description : Watches a scanned 7-segment bus (active-high segments,
//               active-low digit selects), captures each digit's pattern once
//               it has been stable for STABLE_CYCLES samples, flags unknown
//               glyphs and select collisions, and pulses frame_valid when
//               every digit has been refreshed.
//               Optional: define SEG7_SCAN_DP_EN to add the decimal point
//               (dp_in / dp_out) to the captured pair.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   sel_in,
`ifdef SEG7_SCAN_DP_EN
    input  logic                    dp_in,
    output logic [NUM_DIGITS-1:0]   dp_out,
`endif
    output logic [4*NUM_DIGITS-1:0] digit_val,
    output logic [NUM_DIGITS-1:0]   digit_ok,
    output logic                    frame_valid,
    output logic                    sel_err
);

    localparam logic [1:0] c_IDLE   = IDLE;
    localparam logic [1:0] c_SETTLE = SETTLE;
    localparam logic [1:0] c_HOLD   = HOLD;
    localparam logic [7:0] c_STABLE = 8'(STABLE_CYCLES);

    seg_t                    r_seg_q, r_seg_p;
    logic [NUM_DIGITS-1:0]   r_sel_q, r_sel_p;
    logic [1:0]              r_state, w_state_nxt;
    logic [7:0]              r_cnt, w_cnt_nxt;
    logic [NUM_DIGITS-1:0]   r_done;
    logic [4*NUM_DIGITS-1:0] r_val;
    logic [NUM_DIGITS-1:0]   r_ok;
    logic                    r_sel_err;
    logic [7:0]              w_lows;
    logic                    w_onehot, w_multi, w_chg, w_cap, w_frame;
    logic [NUM_DIGITS-1:0]   w_cap_mask;
    logic [3:0]              w_dec_val;
    logic                    w_dec_ok;
`ifdef SEG7_SCAN_DP_EN
    logic                    r_dp_q, r_dp_p;
    logic [NUM_DIGITS-1:0]   r_dp;
`endif

    // Sample the bus and keep the previous sample for change detection;
    // the select resets to "nothing selected" so reset is not a collision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_q <= '0;
            r_seg_p <= '0;
            r_sel_q <= '1;
            r_sel_p <= '1;
`ifdef SEG7_SCAN_DP_EN
            r_dp_q  <= 1'b0;
            r_dp_p  <= 1'b0;
`endif
        end else begin
            r_seg_q <= seg_in;
            r_seg_p <= r_seg_q;
            r_sel_q <= sel_in;
            r_sel_p <= r_sel_q;
`ifdef SEG7_SCAN_DP_EN
            r_dp_q  <= dp_in;
            r_dp_p  <= r_dp_q;
`endif
        end
    end

    // Count asserted (low) selects in the sampled pair
    always_comb begin
        w_lows = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_lows = w_lows + {7'd0, ~r_sel_q[i]};
        end
    end

    assign w_onehot = (w_lows == 8'd1);
    assign w_multi  = (w_lows > 8'd1);
`ifdef SEG7_SCAN_DP_EN
    assign w_chg = (r_seg_q != r_seg_p) || (r_sel_q != r_sel_p) || (r_dp_q != r_dp_p);
`else
    assign w_chg = (r_seg_q != r_seg_p) || (r_sel_q != r_sel_p);
`endif

    seg7_pattern_decode u_decode (
        .i_pattern (r_seg_q),
        .o_value   (w_dec_val),
        .o_ok      (w_dec_ok)
    );

    // Stability FSM: next state, saturating count and capture decision
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cap       = 1'b0;
        if (!w_onehot) begin
            w_state_nxt = c_IDLE;
            w_cnt_nxt   = 8'd0;
        end else begin
            case (r_state)
                c_SETTLE: w_cnt_nxt = w_chg ? 8'd1 :
                                      ((r_cnt >= c_STABLE) ? c_STABLE : r_cnt + 8'd1);
                c_HOLD:   w_cnt_nxt = w_chg ? 8'd1 : r_cnt;
                default:  w_cnt_nxt = 8'd1;
            endcase
            if ((r_state == c_HOLD) && !w_chg) begin
                w_state_nxt = c_HOLD;
            end else if (w_cnt_nxt >= c_STABLE) begin
                w_state_nxt = c_HOLD;
                w_cap       = 1'b1;
            end else begin
                w_state_nxt = c_SETTLE;
            end
        end
    end

    assign w_cap_mask = w_cap ? ~r_sel_q : '0;
    assign w_frame    = &r_done;

    // State, capture registers, frame bookkeeping and sticky select error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= 8'd0;
            r_done    <= '0;
            r_val     <= '0;
            r_ok      <= '0;
            r_sel_err <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
            r_dp      <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_multi) begin
                r_sel_err <= 1'b1;
            end
            // A capture landing on the clearing edge starts the next frame
            r_done <= (w_frame ? '0 : r_done) | w_cap_mask;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_cap_mask[i]) begin
                    r_val[4*i +: 4] <= w_dec_val;
                    r_ok[i]         <= w_dec_ok;
`ifdef SEG7_SCAN_DP_EN
                    r_dp[i]         <= r_dp_q;
`endif
                end
            end
        end
    end

    assign digit_val   = r_val;
    assign digit_ok    = r_ok;
    assign frame_valid = w_frame;
    assign sel_err     = r_sel_err;
`ifdef SEG7_SCAN_DP_EN
    assign dp_out      = r_dp;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_decoder
// Description : Self-checking bench for seg7_scan_decoder: decode table
//               vectors, directed multi-cycle sequences and random scanning
//               checked against a run-length reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_decoder;

    localparam int ND = 4;
    localparam int S  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    seg_in;
    logic [ND-1:0] sel_in;
    logic [4*ND-1:0] digit_val;
    logic [ND-1:0] digit_ok;
    logic          frame_valid;
    logic          sel_err;
`ifdef SEG7_SCAN_DP_EN
    logic          dp_in = 1'b0;
    logic [ND-1:0] dp_out;
`endif

    seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .sel_in      (sel_in),
`ifdef SEG7_SCAN_DP_EN
        .dp_in       (dp_in),
        .dp_out      (dp_out),
`endif
        .digit_val   (digit_val),
        .digit_ok    (digit_ok),
        .frame_valid (frame_valid),
        .sel_err     (sel_err)
    );

    always #5 clk = ~clk;

    int n_cmp    = 0;
    int n_bad    = 0;
    int n_frames = 0;

    // Glyph table indexed by hex value
    logic [6:0] pat_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    // Reference model: last sampled pair, its run length, expected outputs
    logic [6:0]      m_pseg;
    logic [ND-1:0]   m_psel;
    int              m_run;
    logic [4*ND-1:0] m_val;
    logic [ND-1:0]   m_ok, m_done;
    logic            m_err;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void ref_decode(input logic [6:0] p, output logic [3:0] v, output logic k);
        v = 4'h0;
        k = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pat_tab[i] == p) begin
                v = 4'(i);
                k = 1'b1;
            end
        end
    endfunction

    task automatic model_reset();
        m_pseg = '0;
        m_psel = '1;
        m_run  = 0;
        m_val  = '0;
        m_ok   = '0;
        m_done = '0;
        m_err  = 1'b0;
    endtask

    // One rising edge: decisions act on the pair sampled at the previous
    // edge; a pair seen S times in a row is captured on the next edge
    task automatic model_edge(input logic [6:0] seg, input logic [ND-1:0] sel);
        int lows;
        logic [3:0] v;
        logic k;
        lows = $countones(~m_psel);
        if (m_done == '1) m_done = '0;
        if (lows >= 2) m_err = 1'b1;
        if (lows == 1 && m_run == S) begin
            for (int d = 0; d < ND; d++) begin
                if (!m_psel[d]) begin
                    ref_decode(m_pseg, v, k);
                    m_val[4*d +: 4] = v;
                    m_ok[d]   = k;
                    m_done[d] = 1'b1;
                end
            end
        end
        if (seg == m_pseg && sel == m_psel) m_run = (m_run < 1000) ? m_run + 1 : m_run;
        else m_run = 1;
        m_pseg = seg;
        m_psel = sel;
    endtask

    // Drive one sample, clock it, and check every output against the model
    task automatic cyc(input logic [6:0] seg, input logic [ND-1:0] sel);
        seg_in = seg;
        sel_in = sel;
        @(posedge clk);
        model_edge(seg, sel);
        #1;
        cmp("model_digit_val", 32'(digit_val), 32'(m_val));
        cmp("model_digit_ok", 32'(digit_ok), 32'(m_ok));
        cmp("model_frame_valid", 32'(frame_valid), 32'(m_done == '1));
        cmp("model_sel_err", 32'(sel_err), 32'(m_err));
        if (frame_valid) n_frames++;
    endtask

    task automatic hold(input logic [6:0] seg, input int d, input int n);
        for (int i = 0; i < n; i++) cyc(seg, ~(4'b0001 << d));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        seg_in = '0;
        sel_in = '1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [6:0] seg;
        int         dig;
        logic [3:0] val;
        logic       ok;
    } vec_t;

    vec_t vecs [19];

    initial begin
        int f0;
        vecs[0]  = '{7'b1111110, 0, 4'h0, 1'b1};
        vecs[1]  = '{7'b0110000, 1, 4'h1, 1'b1};
        vecs[2]  = '{7'b1101101, 2, 4'h2, 1'b1};
        vecs[3]  = '{7'b1111001, 3, 4'h3, 1'b1};
        vecs[4]  = '{7'b0110011, 0, 4'h4, 1'b1};
        vecs[5]  = '{7'b1011011, 1, 4'h5, 1'b1};
        vecs[6]  = '{7'b1011111, 2, 4'h6, 1'b1};
        vecs[7]  = '{7'b1110000, 3, 4'h7, 1'b1};
        vecs[8]  = '{7'b1111111, 0, 4'h8, 1'b1};
        vecs[9]  = '{7'b1111011, 1, 4'h9, 1'b1};
        vecs[10] = '{7'b1110111, 2, 4'hA, 1'b1};
        vecs[11] = '{7'b0011111, 3, 4'hB, 1'b1};
        vecs[12] = '{7'b1001110, 0, 4'hC, 1'b1};
        vecs[13] = '{7'b0111101, 1, 4'hD, 1'b1};
        vecs[14] = '{7'b1001111, 2, 4'hE, 1'b1};
        vecs[15] = '{7'b1000111, 3, 4'hF, 1'b1};
        vecs[16] = '{7'b0000000, 0, 4'h0, 1'b0};
        vecs[17] = '{7'b0000001, 1, 4'h0, 1'b0};
        vecs[18] = '{7'b1010101, 2, 4'h0, 1'b0};

        rst    = 1'b0;
        seg_in = '0;
        sel_in = '1;
        model_reset();

        // Reset state
        do_reset();
        #1;
        cmp("reset_digit_val", 32'(digit_val), 32'h0);
        cmp("reset_digit_ok", 32'(digit_ok), 32'h0);
        cmp("reset_frame_valid", 32'(frame_valid), 32'h0);
        cmp("reset_sel_err", 32'(sel_err), 32'h0);

        // Basic capture: not at edge 4, captured at edge 5
        hold(7'b1101101, 0, 4);
        cmp("basic_edge4_ok", 32'(digit_ok[0]), 32'h0);
        hold(7'b1101101, 0, 1);
        cmp("basic_edge5_val", 32'(digit_val[3:0]), 32'h2);
        cmp("basic_edge5_ok", 32'(digit_ok[0]), 32'h1);

        // Decode table vectors
        do_reset();
        for (int i = 0; i < 19; i++) begin
            hold(vecs[i].seg, vecs[i].dig, S + 1);
            cmp($sformatf("table%0d_val", i), 32'(digit_val[4*vecs[i].dig +: 4]), 32'(vecs[i].val));
            cmp($sformatf("table%0d_ok", i), 32'(digit_ok[vecs[i].dig]), 32'(vecs[i].ok));
        end

        // Full frame 1,7,A,F then a second scan
        do_reset();
        f0 = n_frames;
        hold(7'b0110000, 0, 6);
        hold(7'b1110000, 1, 6);
        hold(7'b1110111, 2, 6);
        hold(7'b1000111, 3, 6);
        cmp("frame_digit_val", 32'(digit_val), 32'hFA71);
        cmp("frame_digit_ok", 32'(digit_ok), 32'hF);
        cmp("frame_count1", 32'(n_frames - f0), 32'd1);
        hold(7'b0110000, 0, 6);
        hold(7'b1110000, 1, 6);
        hold(7'b1110111, 2, 6);
        cmp("frame_partial_scan", 32'(n_frames - f0), 32'd1);
        hold(7'b1000111, 3, 6);
        cmp("frame_count2", 32'(n_frames - f0), 32'd2);

        // Glitch rejection on digit 1
        do_reset();
        hold(7'b1111111, 1, 3);
        cmp("glitch_no8_ok", 32'(digit_ok[1]), 32'h0);
        for (int i = 0; i < 5; i++) begin
            hold(7'b1111110, 1, 1);
            cmp("glitch_val", 32'(digit_val[7:4]), 32'h0);
        end
        cmp("glitch_zero_ok", 32'(digit_ok[1]), 32'h1);

        // Unrecognised pattern still counts toward the frame
        do_reset();
        f0 = n_frames;
        hold(7'b1111001, 2, 5);
        cmp("unrec_pre_val", 32'(digit_val[11:8]), 32'h3);
        hold(7'b0110000, 0, 5);
        hold(7'b0110000, 1, 5);
        hold(7'b0110000, 3, 5);
        cmp("unrec_frame1", 32'(n_frames - f0), 32'd1);
        hold(7'b0000001, 2, 5);
        cmp("unrec_ok", 32'(digit_ok[2]), 32'h0);
        cmp("unrec_val", 32'(digit_val[11:8]), 32'h0);
        hold(7'b1101101, 0, 5);
        hold(7'b1101101, 1, 5);
        hold(7'b1101101, 3, 5);
        cmp("unrec_done_frame2", 32'(n_frames - f0), 32'd2);

        // Select collision: sticky error, no capture meanwhile
        do_reset();
        for (int i = 0; i < 6; i++) cyc(7'b0110000, 4'b1100);
        cmp("selerr_set", 32'(sel_err), 32'h1);
        cmp("selerr_no_cap_ok", 32'(digit_ok), 32'h0);
        cmp("selerr_no_cap_val", 32'(digit_val), 32'h0);
        hold(7'b0110000, 0, 5);
        cmp("selerr_sticky", 32'(sel_err), 32'h1);
        cmp("selerr_after_cap", 32'(digit_val[3:0]), 32'h1);

        // Reset mid-frame discards the partial frame
        do_reset();
        f0 = n_frames;
        hold(7'b1011011, 0, 5);
        hold(7'b1011111, 1, 5);
        rst = 1'b1;
        #1;
        cmp("midrst_digit_val", 32'(digit_val), 32'h0);
        cmp("midrst_digit_ok", 32'(digit_ok), 32'h0);
        cmp("midrst_frame", 32'(frame_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        hold(7'b1111110, 2, 5);
        hold(7'b1111110, 3, 5);
        cmp("midrst_no_frame", 32'(n_frames - f0), 32'd0);
        hold(7'b1111110, 0, 5);
        hold(7'b1111110, 1, 5);
        cmp("midrst_frame_after_all", 32'(n_frames - f0), 32'd1);

        // Random scanning against the model
        do_reset();
        for (int t = 0; t < 300; t++) begin
            int r, d, n;
            logic [6:0] sg;
            logic [ND-1:0] sl;
            r  = int'($urandom_range(0, 19));
            d  = int'($urandom_range(0, ND - 1));
            n  = int'($urandom_range(1, 7));
            sg = ($urandom_range(0, 3) == 0) ? 7'($urandom) : pat_tab[$urandom_range(0, 15)];
            sl = ~(4'b0001 << d);
            if (r == 0) sl = 4'b1111;
            else if (r == 1 && t > 200) sl = 4'b0101;
            for (int i = 0; i < n; i++) cyc(sg, sl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
